fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the rv32i core.
- Consumes redirect requests (jmp_enable/jmp_addr) from the branch controller.
- Drives a single-outstanding req/ack instruction-memory interface and presents fetched instructions to decode with a valid/ready handshake.
- Issues a one-cycle flush on every accepted redirect and traps misaligned jump targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
jmp_enable  in  1  redirect request from branch controller, sampled every cycle
jmp_addr  in  32  redirect target
imem_req  out  1  instruction-memory request
imem_addr  out  32  fetch address; stable while imem_req=1 and no ack
imem_ack  in  1  request completed; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  inst/inst_pc valid to decode
inst  out  32  instruction word
inst_pc  out  32  address of inst
inst_ready  in  1  decode accepts inst this cycle
flush  out  1  one-cycle pulse: younger pipeline state must be discarded
trap_misaligned  out  1  one-cycle pulse: rejected redirect target
trap_addr  out  32  offending target, held until next trap

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=IDLE. All outputs 0 except imem_addr=RESET_PC.
- States:
  - IDLE: leaves to REQ one cycle after rst_n rises.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4 (mod 2^32), go to VALID.
  - VALID: inst_valid=1, imem_req=0. When inst_ready=1, go to REQ next cycle. Minimum 2 cycles per instruction with zero-wait memory.
  - DROP: imem_req=1 with the old address until imem_ack; data discarded; then go to REQ with the new pc.
- Handshake rule: a request, once raised, is never withdrawn or re-addressed before ack.
- Redirect (jmp_enable=1, jmp_addr[1:0]==0, state!=IDLE):
  - pc<=jmp_addr; flush=1 next cycle; inst_valid=0 next cycle.
  - In REQ without ack: go to DROP.
  - In REQ with ack same cycle: discard rdata, go to REQ.
  - In VALID: redirect beats inst_ready; the held instruction is dropped; go to REQ.
  - In DROP: pc is overwritten again (last redirect wins); stay in DROP.
- Misaligned redirect (jmp_addr[1:0]!=0): ignored for sequencing. trap_misaligned=1 next cycle, trap_addr<=jmp_addr, no flush, pc unchanged.
- jmp_enable in IDLE is ignored.
- Reset mid-request: imem_req drops immediately (async); the memory must tolerate abandonment.

Optional Feature:
- Macro FETCH_SEQUENCER_PERF_EN. When defined, adds two outputs:
  - fetch_count, 32-bit: increments on each accepted decode transfer.
  - redirect_count, 32-bit: increments on each accepted aligned redirect.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, VALID, DROP).
  - INST_BYTES=4.
  - Alignment-check helper function.
- One natural sub-module, fetch_perf_counters, instantiated only under FETCH_SEQUENCER_PERF_EN.
- Everything else is in one module.

Test Plan:
- Reset release, zero-wait ack, inst_ready=1: imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches; inst_valid every 2nd cycle.
- Ack delayed 3 cycles: imem_addr=0x4 held stable and imem_req=1 throughout; inst captured only on the ack cycle.
- inst_ready=0 for 5 cycles in VALID: inst/inst_pc held; no new imem_req.
- jmp_enable=1, jmp_addr=0x100 while a request to 0x8 is outstanding (no ack): DROP, old ack data never seen at inst_valid; next fetch addr 0x100; flush pulses once.
- jmp_addr=0x102: trap_misaligned pulses, trap_addr=0x102, no flush; next fetch continues at pc+4.
- rst_n low mid-REQ: imem_req=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the rv32i fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // Only the two low address bits decide word alignment.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running fetch statistics; only built when FETCH_SEQUENCER_PERF_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_xfer,
    input  logic        redirect,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count    <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if (fetch_xfer) fetch_count <= fetch_count + 32'd1;
            if (redirect)   redirect_count <= redirect_count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and single-outstanding instruction fetch sequencer for the rv32i core.
// Optional counters (fetch_count/redirect_count) enabled by FETCH_SEQUENCER_PERF_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jmp_enable,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        flush,
    output logic        trap_misaligned,
    output logic [31:0] trap_addr
`ifdef FETCH_SEQUENCER_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         jmp_live;
    logic         redirect;
    logic         misaligned_jmp;

    assign jmp_live       = jmp_enable && (state != IDLE);
    assign redirect       = jmp_live && is_aligned(jmp_addr[1:0]);
    assign misaligned_jmp = jmp_live && !is_aligned(jmp_addr[1:0]);

    // Handshakes: imem_req stays high with imem_addr frozen until the cycle imem_ack
    // is seen; inst_valid holds inst/inst_pc until a cycle with inst_ready=1, and a
    // same-cycle aligned redirect cancels that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            imem_req        <= 1'b0;
            imem_addr       <= RESET_PC;
            inst_valid      <= 1'b0;
            inst            <= 32'd0;
            inst_pc         <= 32'd0;
            flush           <= 1'b0;
            trap_misaligned <= 1'b0;
            trap_addr       <= 32'd0;
        end else begin
            flush           <= redirect;
            trap_misaligned <= misaligned_jmp;
            if (misaligned_jmp) trap_addr <= jmp_addr;

            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (redirect) begin
                        pc <= jmp_addr;
                        if (imem_ack) begin
                            imem_addr <= jmp_addr;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        pc         <= pc + INST_BYTES;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        pc         <= jmp_addr;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= jmp_addr;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc;
                        state      <= REQ;
                    end
                end
                DROP: begin
                    // The stale request must still complete; its data is never presented.
                    if (redirect) pc <= jmp_addr;
                    if (imem_ack) begin
                        imem_addr <= redirect ? jmp_addr : pc;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_SEQUENCER_PERF_EN
    logic fetch_xfer;
    assign fetch_xfer = (state == VALID) && inst_ready && !redirect;

    fetch_perf_counters u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_xfer     (fetch_xfer),
        .redirect       (redirect),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: program-order model plus randomized memory/decode/redirects.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        jmp_enable;
  logic [31:0] jmp_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        flush;
  logic        trap_misaligned;
  logic [31:0] trap_addr;
`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .jmp_enable      (jmp_enable),
    .jmp_addr        (jmp_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .flush           (flush),
    .trap_misaligned (trap_misaligned),
    .trap_addr       (trap_addr)
`ifdef FETCH_SEQUENCER_PERF_EN
    ,
    .fetch_count     (fetch_count),
    .redirect_count  (redirect_count)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- instruction memory model ----------------
  int mem_delay = 0;
  bit mem_rand = 1'b0;
  bit mem_busy = 1'b0;
  int mem_left = 0;

  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
      end
      if (mem_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_left--;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Program order: instructions come from consecutive words starting at the last
  // accepted aligned redirect target (or RESET_PC after reset).
  logic [63:0] exp_q[$];
  logic [31:0] model_next;
  bit          in_idle = 1'b0;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_next, mem_word(model_next)});
      model_next = model_next + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    model_next = start;
    refill();
  endtask

  bit          exp_flush = 1'b0;
  bit          exp_trap = 1'b0;
  logic [31:0] exp_trap_addr = 32'd0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  bit          prev_held = 1'b0;
  logic [31:0] prev_inst = 32'd0;
  logic [31:0] prev_pc = 32'd0;
  int          n_xfer = 0;
  logic [31:0] perf_fetch = 32'd0;
  logic [31:0] perf_redir = 32'd0;
  bit          acc, al, mis;
  logic [63:0] e;

  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      check1("rst_imem_req", imem_req, 1'b0);
      check1("rst_inst_valid", inst_valid, 1'b0);
      check1("rst_flush", flush, 1'b0);
      check1("rst_trap", trap_misaligned, 1'b0);
      check32("rst_imem_addr", imem_addr, RESET_PC);
      exp_flush = 1'b0;
      exp_trap = 1'b0;
      exp_trap_addr = 32'd0;
      prev_pending = 1'b0;
      prev_held = 1'b0;
      perf_fetch = 32'd0;
      perf_redir = 32'd0;
      model_restart(RESET_PC);
    end else begin
      check1("flush", flush, exp_flush);
      check1("trap_misaligned", trap_misaligned, exp_trap);
      check32("trap_addr", trap_addr, exp_trap_addr);
      if (exp_flush) check1("valid_after_redirect", inst_valid, 1'b0);
      if (prev_pending) begin
        check1("req_held", imem_req, 1'b1);
        check32("addr_stable", imem_addr, prev_addr);
      end
      if (inst_valid) check1("no_req_while_valid", imem_req, 1'b0);
      if (prev_held) begin
        check1("valid_held", inst_valid, 1'b1);
        check32("inst_held", inst, prev_inst);
        check32("inst_pc_held", inst_pc, prev_pc);
      end

      acc = jmp_enable && !in_idle;
      al  = acc && (jmp_addr[1:0] == 2'b00);
      mis = acc && !al;

      if (inst_valid && inst_ready && !al) begin
        e = exp_q.pop_front();
        check32("sb_inst_pc", inst_pc, e[63:32]);
        check32("sb_inst", inst, e[31:0]);
        n_xfer++;
        perf_fetch = perf_fetch + 32'd1;
        refill();
      end
      if (al) begin
        model_restart(jmp_addr);
        perf_redir = perf_redir + 32'd1;
      end

      exp_flush = al;
      exp_trap  = mis;
      if (mis) exp_trap_addr = jmp_addr;
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      prev_held    = inst_valid && !inst_ready && !al;
      prev_inst    = inst;
      prev_pc      = inst_pc;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  bit found;
  int xfer_start;

  initial begin
    rst_n = 1'b0;
    jmp_enable = 1'b0;
    jmp_addr = 32'd0;
    inst_ready = 1'b0;
    repeat (3) tick();
    check1("reset_imem_req", imem_req, 1'b0);
    check32("reset_imem_addr", imem_addr, RESET_PC);
    check1("reset_inst_valid", inst_valid, 1'b0);
    check32("reset_inst", inst, 32'd0);
    check32("reset_inst_pc", inst_pc, 32'd0);
    check1("reset_flush", flush, 1'b0);
    check1("reset_trap", trap_misaligned, 1'b0);
    check32("reset_trap_addr", trap_addr, 32'd0);

    // zero-wait memory, decode always ready
    mem_delay = 0;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    in_idle = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      in_idle = 1'b0;
      if (k % 2 == 1) begin
        check1("zw_req", imem_req, 1'b1);
        check32("zw_addr", imem_addr, 32'((k - 1) * 2));
        check1("zw_valid_low", inst_valid, 1'b0);
      end else begin
        check1("zw_valid_high", inst_valid, 1'b1);
        check32("zw_inst_pc", inst_pc, 32'((k - 2) * 2));
      end
    end

    // ack delayed by 3 cycles on the fetch of 0xC
    mem_delay = 3;
    for (int k = 7; k <= 10; k++) begin
      tick();
      check1("wait_req", imem_req, 1'b1);
      check32("wait_addr", imem_addr, 32'h0000_000C);
      check1("wait_valid_low", inst_valid, 1'b0);
    end
    inst_ready = 1'b0;

    // decode stalls 5 cycles
    for (int k = 11; k <= 15; k++) begin
      tick();
      check1("stall_valid", inst_valid, 1'b1);
      check32("stall_inst_pc", inst_pc, 32'h0000_000C);
      check32("stall_inst", inst, mem_word(32'h0000_000C));
      check1("stall_no_req", imem_req, 1'b0);
    end
    inst_ready = 1'b1;
    mem_delay = 4;

    // redirect to 0x100 while the fetch of 0x10 is outstanding
    tick();
    check1("pre_jmp_req", imem_req, 1'b1);
    check32("pre_jmp_addr", imem_addr, 32'h0000_0010);
    jmp_enable = 1'b1;
    jmp_addr = 32'h0000_0100;
    tick();
    jmp_enable = 1'b0;
    check1("drop_flush", flush, 1'b1);
    check1("drop_req", imem_req, 1'b1);
    check32("drop_old_addr", imem_addr, 32'h0000_0010);
    tick();
    check1("drop_flush_once", flush, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h0000_0100) found = 1'b1;
    end
    check1("redirect_fetch_0x100", found, 1'b1);
    mem_delay = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (inst_valid) found = 1'b1;
    end
    check1("redirect_delivers", found, 1'b1);
    check32("redirect_inst_pc", inst_pc, 32'h0000_0100);

    // misaligned target
    jmp_enable = 1'b1;
    jmp_addr = 32'h0000_0102;
    tick();
    jmp_enable = 1'b0;
    check1("mis_trap", trap_misaligned, 1'b1);
    check32("mis_trap_addr", trap_addr, 32'h0000_0102);
    check1("mis_no_flush", flush, 1'b0);
    tick();
    check1("mis_trap_pulse", trap_misaligned, 1'b0);
    check32("mis_trap_addr_held", trap_addr, 32'h0000_0102);
    repeat (10) tick();

    // reset in the middle of a request; jmp during IDLE must be ignored
    mem_delay = 5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_req) found = 1'b1;
    end
    check1("pre_reset_req", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_reset_req", imem_req, 1'b0);
    check1("async_reset_valid", inst_valid, 1'b0);
    tick();
    tick();
    mem_delay = 0;
    rst_n = 1'b1;
    in_idle = 1'b1;
    jmp_enable = 1'b1;
    jmp_addr = 32'h0000_0200;
    tick();
    in_idle = 1'b0;
    jmp_enable = 1'b0;
    check1("restart_req", imem_req, 1'b1);
    check32("restart_addr", imem_addr, RESET_PC);
    tick();
    check1("idle_jmp_no_flush", flush, 1'b0);

    // randomized traffic
    mem_rand = 1'b1;
    xfer_start = n_xfer;
    repeat (2000) begin
      logic [31:0] a;
      tick();
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) begin
        a = $urandom;
        if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8;
        else if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        else if (a[1:0] == 2'b00) a[0] = 1'b1;
        jmp_enable = 1'b1;
        jmp_addr = a;
      end else begin
        jmp_enable = 1'b0;
      end
    end
    jmp_enable = 1'b0;
    inst_ready = 1'b1;
    repeat (8) tick();
    check1("random_progress", (n_xfer - xfer_start) > 100, 1'b1);
`ifdef FETCH_SEQUENCER_PERF_EN
    check32("perf_fetch_count", fetch_count, perf_fetch);
    check32("perf_redirect_count", redirect_count, perf_redir);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
